// File: rtl/chess_pkg.sv
// Shared types and constants for the chess cursor/move controller.
// CURSOR_WRAP_EN selects wrap-around (defined) or saturating (undefined) board edges.
package chess_pkg;
    localparam int SQ_W        = 6;
    localparam int CURSOR_LSB  = 0;
    localparam int SOURCE_LSB  = 6;
    localparam int SELECT_BIT  = 12;
    localparam int PENDING_BIT = 13;
    localparam int MOVE_W      = 14;

    localparam int NUM_BTN    = 5;
    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_CENTER = 4;

    typedef enum logic [1:0] {IDLE, SELECTED, COMMIT} state_t;

    // One board coordinate step; inc has priority over dec.
    function automatic logic [2:0] coord_step(input logic [2:0] v, input logic inc, input logic dec);
        logic [2:0] r;
        r = v;
`ifdef CURSOR_WRAP_EN
        if (inc)      r = v + 3'd1;
        else if (dec) r = v - 3'd1;
`else
        if (inc)      r = (v == 3'd7) ? v : v + 3'd1;
        else if (dec) r = (v == 3'd0) ? v : v - 3'd1;
`endif
        return r;
    endfunction
endpackage

// File: rtl/button_debounce.sv
// One pushbutton: 2-flop synchronizer, stable-count debouncer and registered rise pulse.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            press <= 1'b0;
            // Any sample agreeing with the accepted level restarts the count.
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= sync[1];
                press <= sync[1];
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/move_cursor_ctrl.sv
// Chessboard cursor and move-selection controller driven by five debounced buttons.
// Board edge behaviour follows CURSOR_WRAP_EN (see chess_pkg).
module move_cursor_ctrl
    import chess_pkg::*;
#(
    parameter int              DEBOUNCE_CYCLES = 1000000,
    parameter logic [SQ_W-1:0] CURSOR_INIT     = 6'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              btn_center,
    input  logic              move_ack,
    output logic [MOVE_W-1:0] moveData
);
    logic [NUM_BTN-1:0] raw, press;

    assign raw = {btn_center, btn_right, btn_left, btn_down, btn_up};

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [NUM_BTN-1:0] (
        .clk   (clk),
        .reset (reset),
        .btn   (raw),
        .press (press)
    );

    state_t          state, state_n;
    logic [SQ_W-1:0] cursor, cursor_n, source, source_n, moved;
    logic            sel, sel_n, pend, pend_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cursor <= CURSOR_INIT;
            source <= '0;
            sel    <= 1'b0;
            pend   <= 1'b0;
        end else begin
            state  <= state_n;
            cursor <= cursor_n;
            source <= source_n;
            sel    <= sel_n;
            pend   <= pend_n;
        end
    end

    always_comb begin
        state_n  = state;
        cursor_n = cursor;
        source_n = source;
        sel_n    = sel;
        pend_n   = pend;
        moved    = {coord_step(cursor[5:3], press[BTN_RIGHT], press[BTN_LEFT]),
                    coord_step(cursor[2:0], press[BTN_UP],    press[BTN_DOWN])};
        case (state)
            IDLE: begin
                cursor_n = moved;
                if (press[BTN_CENTER]) begin
                    source_n = cursor;
                    sel_n    = 1'b1;
                    state_n  = SELECTED;
                end
            end
            SELECTED: begin
                cursor_n = moved;
                if (press[BTN_CENTER]) begin
                    if (cursor == source) begin
                        sel_n   = 1'b0;
                        state_n = IDLE;
                    end else begin
                        // Destination is the square compared against, so hold it.
                        cursor_n = cursor;
                        pend_n   = 1'b1;
                        state_n  = COMMIT;
                    end
                end
            end
            COMMIT: begin
                if (move_ack) begin
                    pend_n  = 1'b0;
                    sel_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign moveData[CURSOR_LSB +: SQ_W] = cursor;
    assign moveData[SOURCE_LSB +: SQ_W] = source;
    assign moveData[SELECT_BIT]         = sel;
    assign moveData[PENDING_BIT]        = pend;
endmodule

// File: tb/tb_move_cursor_ctrl.sv
// Self-checking bench for move_cursor_ctrl: vector table, corner sequences and a
// randomized run against a cycle-level reference model.
module tb_move_cursor_ctrl;
    localparam int DB = 4;

    logic        clk, reset;
    logic        btn_up, btn_down, btn_left, btn_right, btn_center, move_ack;
    logic [13:0] moveData;

    int tests = 0;
    int fails = 0;

    move_cursor_ctrl #(.DEBOUNCE_CYCLES(DB), .CURSOR_INIT(6'd0)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_center (btn_center),
        .move_ack   (move_ack),
        .moveData   (moveData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a button's accepted level flips once the synchronized
    // samples (raw delayed two edges) have differed from it for DB edges in a row.
    logic [4:0] rh [0:DB+1];
    logic [4:0] lvl, prs;
    int         cur, src, lt, nm;
    bit         msel, mpend, commit_now, agree;

    function automatic int step(input int v, input bit inc, input bit dec);
`ifdef CURSOR_WRAP_EN
        if (inc) return (v + 1) % 8;
        if (dec) return (v + 7) % 8;
`else
        if (inc) return (v < 7) ? v + 1 : 7;
        if (dec) return (v > 0) ? v - 1 : 0;
`endif
        return v;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= DB + 1; i++) rh[i] = '0;
            lvl = '0; prs = '0; cur = 0; src = 0; msel = 0; mpend = 0;
        end else begin
            if (mpend) begin
                if (move_ack) begin mpend = 0; msel = 0; end
            end else begin
                commit_now = 0;
                if (prs[4]) begin
                    if (!msel) begin src = cur; msel = 1; end
                    else if (cur == src) msel = 0;
                    else begin mpend = 1; commit_now = 1; end
                end
                if (!commit_now) begin
                    lt  = step(cur / 8, prs[3], prs[2]);
                    nm  = step(cur % 8, prs[0], prs[1]);
                    cur = lt * 8 + nm;
                end
            end
            for (int i = DB + 1; i > 0; i--) rh[i] = rh[i-1];
            rh[0] = {btn_center, btn_right, btn_left, btn_down, btn_up};
            prs = '0;
            for (int b = 0; b < 5; b++) begin
                agree = 0;
                for (int k = 2; k <= DB + 1; k++) if (rh[k][b] == lvl[b]) agree = 1;
                if (!agree) begin
                    lvl[b] = ~lvl[b];
                    prs[b] = lvl[b];
                end
            end
        end
    end

    always @(negedge clk)
        if (!reset) chk("scoreboard", 32'(moveData), 32'({mpend, msel, 6'(src), 6'(cur)}));

    task automatic set_btn(input logic [4:0] m);
        {btn_center, btn_right, btn_left, btn_down, btn_up} = m;
    endtask

    task automatic press(input logic [4:0] m, input int hold, input int gap);
        set_btn(m);
        repeat (hold) @(negedge clk);
        set_btn(5'd0);
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1 chk("reset_state", 32'(moveData), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [4:0] btn;
        int         hold;
        logic [5:0] exp_cur;
    } vec_t;
    vec_t vt [7];

    initial begin
        reset = 1'b1; move_ack = 1'b0; set_btn(5'd0);
        #1 chk("reset_async", 32'(moveData), 32'd0);

`ifdef CURSOR_WRAP_EN
        vt[0] = '{5'b00001, 10, 6'd1};  vt[1] = '{5'b00010, 8, 6'd0};
        vt[2] = '{5'b00100, 8, 6'd56};  vt[3] = '{5'b01000, 8, 6'd0};
        vt[4] = '{5'b00011, 8, 6'd1};   vt[5] = '{5'b01100, 8, 6'd9};
        vt[6] = '{5'b00110, 8, 6'd0};
`else
        vt[0] = '{5'b00001, 10, 6'd1};  vt[1] = '{5'b00010, 8, 6'd0};
        vt[2] = '{5'b00100, 8, 6'd0};   vt[3] = '{5'b01000, 8, 6'd8};
        vt[4] = '{5'b00011, 8, 6'd9};   vt[5] = '{5'b01100, 8, 6'd17};
        vt[6] = '{5'b00110, 8, 6'd8};
`endif
        @(negedge clk);
        reset = 1'b0;
        foreach (vt[i]) begin
            press(vt[i].btn, vt[i].hold, 10);
            chk($sformatf("vec%0d_cursor", i), 32'(moveData[5:0]), 32'(vt[i].exp_cur));
            chk($sformatf("vec%0d_flags", i), 32'(moveData[13:12]), 32'd0);
        end

        // Bouncing right button never settles, then a clean hold moves once.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            btn_right = ~btn_right;
            repeat (2) @(negedge clk);
        end
        chk("bounce_no_move", 32'(moveData[5:0]), 32'd0);
        press(5'b01000, 10, 10);
        chk("bounce_then_hold", 32'(moveData[5:0]), 32'd8);

        // Select 9, move to 17, commit, hold, acknowledge.
        do_reset();
        press(5'b00001, 8, 10);
        press(5'b01000, 8, 10);
        press(5'b10000, 8, 10);
        chk("select_src", 32'(moveData), 32'({2'b01, 6'd9, 6'd9}));
        press(5'b01000, 8, 10);
        press(5'b10000, 8, 10);
        chk("commit", 32'(moveData), 32'({2'b11, 6'd9, 6'd17}));
        repeat (5) @(negedge clk);
        chk("commit_held", 32'(moveData[13:12]), 32'd3);
        press(5'b00001, 8, 10);
        chk("commit_frozen", 32'(moveData), 32'({2'b11, 6'd9, 6'd17}));
        move_ack = 1'b1;
        @(negedge clk);
        move_ack = 1'b0;
        chk("ack_release", 32'(moveData), 32'({2'b00, 6'd9, 6'd17}));

        // Center twice on the same square cancels without committing.
        press(5'b10000, 8, 10);
        chk("cancel_sel", 32'(moveData[13:12]), 32'd1);
        press(5'b10000, 8, 10);
        chk("cancel_clear", 32'(moveData[13:12]), 32'd0);
        move_ack = 1'b1;
        @(negedge clk);
        move_ack = 1'b0;
        chk("ack_ignored_idle", 32'(moveData[13:12]), 32'd0);

        // Board edges: num 7 + up, let 0 + left.
        do_reset();
        for (int i = 0; i < 7; i++) press(5'b00001, 8, 10);
        chk("up_to_7", 32'(moveData[5:0]), 32'd7);
        press(5'b00001, 8, 10);
`ifdef CURSOR_WRAP_EN
        chk("edge_up", 32'(moveData[5:0]), 32'd0);
`else
        chk("edge_up", 32'(moveData[5:0]), 32'd7);
`endif
        do_reset();
        press(5'b00100, 8, 10);
`ifdef CURSOR_WRAP_EN
        chk("edge_left", 32'(moveData[5:0]), 32'd56);
`else
        chk("edge_left", 32'(moveData[5:0]), 32'd0);
`endif

        // Reset mid-commit clears immediately; button held through release presses once.
        do_reset();
        press(5'b10000, 8, 10);
        press(5'b00001, 8, 10);
        press(5'b10000, 8, 10);
        chk("commit2", 32'(moveData[13:12]), 32'd3);
        #2 reset = 1'b1;
        #1 chk("reset_in_commit", 32'(moveData), 32'd0);
        btn_up = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        press(5'b00000, 1, 10);
        chk("held_through_reset", 32'(moveData[5:0]), 32'd1);

        // Randomized buttons and acknowledges against the model.
        for (int n = 0; n < 80; n++) begin
            set_btn(5'($urandom_range(0, 31)));
            for (int c = 0; c < int'($urandom_range(1, 10)); c++) begin
                move_ack = ($urandom_range(0, 3) == 0);
                @(negedge clk);
            end
        end
        set_btn(5'd0);
        move_ack = 1'b0;
        repeat (12) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/move_cursor_ctrl.md
MOVE_CURSOR_CTRL -- requirements
Module: move_cursor_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of consecutive stable cycles required to accept a button level (10 ms at 100 MHz).
REQ-002 Parameter CURSOR_INIT, default 6'd0, is the cursor square loaded at reset, encoded {let[2:0], num[2:0]}.
REQ-003 Port clk, input, 1 bit: 100 MHz system clock; the block has one clock only.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Ports btn_up, btn_down, btn_left, btn_right, btn_center, input, 1 bit each: raw, asynchronous pushbutton levels, active-high.
REQ-006 Port move_ack, input, 1 bit: the game logic accepts the committed move.
REQ-007 Port moveData, output, 14 bits, with these fields:
- [5:0] cursor / destination square
- [11:6] selected source square
- [12] selection-active flag
- [13] move-pending strobe

Function
REQ-008 Each button SHALL pass through a 2-flop synchronizer, then a debouncer.
- The debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
- Any bounce SHALL restart the count.
REQ-009 A press SHALL be a one-cycle pulse on the debounced rising edge.
- No pulse on release.
- Holding a button SHALL produce exactly one pulse.
REQ-010 Cursor movement on a press pulse:
- up: num+1; down: num-1.
- right: let+1; left: let-1.
- The cursor updates the cycle after the pulse.
REQ-011 Simultaneous pulses:
- up and down together: up wins.
- right and left together: right wins.
- A vertical and a horizontal pulse together SHALL both apply.
REQ-012 The FSM states are IDLE, SELECTED and COMMIT.
REQ-013 IDLE:
- moveData[12]=0, moveData[13]=0.
- A center pulse SHALL latch source=cursor, set [12]=1 and go to SELECTED.
REQ-014 SELECTED, center pulse with cursor==source: cancel, clear [12], go to IDLE.
REQ-015 SELECTED, center pulse with cursor!=source: go to COMMIT with [13]=1 and [12]=1; [5:0] holds the destination and [11:6] the source.
REQ-016 When center and direction pulses occur in the same cycle, center SHALL be evaluated against the pre-move cursor, and the direction SHALL still apply, except in COMMIT.
REQ-017 COMMIT:
- All button pulses SHALL be ignored and the cursor frozen.
- [13] SHALL stay high until move_ack=1 is sampled.
- On the next cycle [13]=0, [12]=0 and state=IDLE; the cursor stays at the destination.
REQ-018 move_ack SHALL be ignored outside COMMIT.
REQ-019 All outputs SHALL be registered, with no combinational path from inputs to moveData.

Reset
REQ-020 While reset=1, the following SHALL hold immediately, regardless of clk:
- cursor=CURSOR_INIT, source=6'd0.
- [12]=0, [13]=0, state=IDLE.
- Synchronizers, debounced levels and counters = 0.
REQ-021 Reset asserted in COMMIT SHALL drop [13] immediately, with no acknowledge required.
REQ-022 A button held through reset release SHALL produce one press once it is debounced after release.

Configuration
REQ-023 Macro CURSOR_WRAP_EN selects edge behaviour at the board edges.
- Defined: let and num SHALL wrap modulo 8 (num 7 + up gives 0; let 0 + left gives 7).
- Undefined: let and num SHALL saturate at 0 and 7, and a press at the edge leaves the cursor unchanged.

Structure
REQ-024 Shared package chess_pkg SHALL hold:
- the moveData field offsets/widths (CURSOR_LSB=0, SOURCE_LSB=6, SELECT_BIT=12, PENDING_BIT=13);
- the FSM state typedef;
- square width SQ_W=6.
REQ-025 Sub-module button_debounce SHALL provide the synchronizer, debounce counter and rise pulse for one button.
- It SHALL be instantiated five times, parameterized by DEBOUNCE_CYCLES.

Verification
REQ-026 All scenarios SHALL run with DEBOUNCE_CYCLES=4 and CURSOR_INIT=0, covering:
- Reset, then btn_up held for 10 cycles -> exactly one move; cursor=6'b000_001; [12]=0.
- btn_right toggling every 2 cycles for 20 cycles, then held -> no move during the toggling; exactly one move after the stable hold; cursor=6'b001_000.
- Center at cursor 6'd9, right, then center -> [11:6]=9, [5:0]=17, [12]=1, [13]=1 held; move_ack pulsed after 5 cycles -> [13]=0 and [12]=0 the next cycle; cursor=17.
- Center twice at the same square -> [12] goes 1 then 0; [13] never asserts.
- Cursor 6'd7 plus up, and cursor 0 plus left -> with CURSOR_WRAP_EN: 6'd0 and 6'b111_000; without it: 6'd7 and 6'd0.
- Reset asserted during COMMIT -> [13]=0 asynchronously, cursor=0, state IDLE; a btn_up press during COMMIT produces no cursor change.
